// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic op codes and arbiter FSM state encodings,
// reused by the pipeline's ALU decoder.
package alu_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/logic_unit_64bit.sv
// Purely combinational bitwise logic unit.
// Ports: a, b - operands; op - operation select; out - bitwise result.
module logic_unit_64bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (op)
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      OP_NOR:  out = ~(a | b);
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a single bitwise logic unit.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the
// result until the consumer takes it.
// Ports: clk, rst (async, active-high); req0_*/req1_* valid/ready/op/a/b
// request channels; rsp_valid/rsp_ready/rsp_id/rsp_data result channel;
// busy (FSM not idle); op_count (saturating count of consumed results).
module logic_unit_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_valid_c;
  logic             grant_c;
  logic             idle_c;
  logic [WIDTH-1:0] result_c;

  assign any_valid_c = req0_valid | req1_valid;
  assign idle_c      = (state_q == ST_IDLE);

  // Lone requester wins; on a tie the requester that did not win last time.
  always_comb begin
    grant_c = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end
  end

  // Ready is combinational so acceptance happens in the same IDLE cycle.
  assign req0_ready = !rst && idle_c && req0_valid && !grant_c;
  assign req1_ready = !rst && idle_c && req1_valid && grant_c;

  logic_unit_64bit #(
    .WIDTH(WIDTH)
  ) u_logic (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .out(result_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          gnt_d        = grant_c;
          last_grant_d = grant_c;
          op_d         = grant_c ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
          a_d          = grant_c ? req1_a : req0_a;
          b_d          = grant_c ? req1_b : req0_b;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = result_c;
        rsp_id_d   = gnt_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= OP_OR;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a reference model predicts grants,
// readiness, latency and results; a negedge monitor compares the DUT to it.
// A second instance with a 2-bit counter shares the stimulus to check saturation.
module tb_logic_unit_arbiter;

  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [WIDTH-1:0] rsp_data;
  logic [15:0]      op_count;

  logic             s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
  logic [WIDTH-1:0] s_rsp_data;
  logic [1:0]       s_op_count;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
  );

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_data(s_rsp_data), .busy(s_busy), .op_count(s_op_count)
  );

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  bit   m_pending;
  int   m_age;
  bit   m_last;
  int   m_done;

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance it by this cycle's handshakes.
  always @(negedge clk) begin
    bit   g;
    bit   acc;
    bit   exp_rv;
    exp_t e;
    if (rst) begin
      chk("rst_req0_ready", WIDTH'(req0_ready), '0);
      chk("rst_req1_ready", WIDTH'(req1_ready), '0);
      chk("rst_rsp_valid", WIDTH'(rsp_valid), '0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_rsp_id", WIDTH'(rsp_id), '0);
      chk("rst_busy", WIDTH'(busy), '0);
      chk("rst_op_count", WIDTH'(op_count), '0);
      m_pending = 1'b0;
      m_age     = 0;
      m_last    = 1'b1;
      m_done    = 0;
      exp_q.delete();
    end else begin
      if (m_pending) m_age++;
      g      = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      acc    = !m_pending && (req0_valid || req1_valid);
      exp_rv = m_pending && (m_age >= 2);

      chk("req0_ready", WIDTH'(req0_ready), WIDTH'(acc && !g));
      chk("req1_ready", WIDTH'(req1_ready), WIDTH'(acc && g));
      chk("rsp_valid", WIDTH'(rsp_valid), WIDTH'(exp_rv));
      chk("busy", WIDTH'(busy), WIDTH'(m_pending && (m_age >= 1)));
      chk("op_count", WIDTH'(op_count), WIDTH'((m_done > 65535) ? 65535 : m_done));
      chk("op_count_sat", WIDTH'(s_op_count), WIDTH'((m_done > 3) ? 3 : m_done));

      if (exp_rv && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", WIDTH'(rsp_id), WIDTH'(e.id));
      end

      if (m_pending && m_age > 40) begin
        total++;
        bad++;
        $display("FAIL timeout: response age %0d exceeds bound 40", m_age);
        m_pending = 1'b0;
        exp_q.delete();
      end

      if (exp_rv && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_pending = 1'b0;
        m_done++;
      end

      if (acc) begin
        e.id   = g;
        e.data = g ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
        exp_q.push_back(e);
        m_pending = 1'b1;
        m_age     = 0;
        m_last    = g;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] ta, tb;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'd0; req1_op = 2'd0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    step(3);
    rst = 1'b0;

    // Single request from req0 (OR)
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 2'd0;
    req0_a = 64'hF0F0_0000_0000_0000; req0_b = 64'h0000_0000_0000_0F0F;
    step(1);
    idle_inputs();
    step(4);

    // All four ops from req1
    ta = 64'hFFFF_0000_FFFF_0000;
    tb = 64'hFF00_FF00_FF00_FF00;
    for (int op = 0; op < 4; op++) begin
      req1_valid = 1'b1; req1_op = 2'(op); req1_a = ta; req1_b = tb;
      step(1);
      idle_inputs();
      step(3);
    end

    // Tie after reset: grants alternate starting at req0
    pulse_reset();
    req0_valid = 1'b1; req0_op = 2'd2; req0_a = 64'h1234_5678_9ABC_DEF0; req0_b = 64'hFFFF;
    req1_valid = 1'b1; req1_op = 2'd3; req1_a = 64'h0F0F; req1_b = 64'hF000_0000_0000_0000;
    rsp_ready  = 1'b1;
    step(12);
    idle_inputs();
    step(1);
    chk("tie_op_count", WIDTH'(op_count), WIDTH'(4));

    // Backpressure: result held 5+ cycles, requesters held off
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step(7);
    rsp_ready = 1'b1;
    step(1);
    idle_inputs();
    step(4);

    // Reset in EXEC: req0 accepted, then reset; next tie must go to req0
    req0_valid = 1'b1; req0_op = 2'd1;
    step(1);
    idle_inputs();
    #2 rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    req0_valid = 1'b1; req1_valid = 1'b1;
    step(1);
    idle_inputs();
    step(4);

    // Saturation: six completions on a 2-bit counter
    pulse_reset();
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'h55; req0_b = 64'hAA00;
    rsp_ready  = 1'b1;
    step(18);
    idle_inputs();
    step(2);
    chk("sat_op_count", WIDTH'(s_op_count), WIDTH'(3));
    chk("six_op_count", WIDTH'(op_count), WIDTH'(6));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op    = 2'($urandom);
      req1_op    = 2'($urandom);
      req0_a     = {$urandom, $urandom};
      req0_b     = {$urandom, $urandom};
      req1_a     = {$urandom, $urandom};
      req1_b     = {$urandom, $urandom};
      rsp_ready  = ($urandom_range(0, 3) != 0);
      step(1);
    end

    idle_inputs();
    rsp_ready = 1'b1;
    step(6);
    chk("drain_empty", WIDTH'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
